// File: rtl/pwm_bank_pkg.sv
// ============================================================================
//  Module      : pwm_bank_pkg
//  Description : Register map constants shared by the PWM bank and its bench.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_bank_pkg;
  localparam int ADDR_EN_OUT    = 'h00;
  localparam int ADDR_PWM_MODE  = 'h01;
  localparam int ADDR_PRESCALE  = 'h02;
  localparam int ADDR_DUTY_BASE = 'h03;
endpackage

`default_nettype wire

// File: rtl/pwm_bank_if.sv
// ============================================================================
//  Module      : pwm_bank_if
//  Description : Register write/read port and PWM outputs of the PWM bank.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pwm_bank_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, pwm_out, period_start
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, pwm_out, period_start
  );
endinterface

`default_nettype wire

// File: rtl/pwm_channel.sv
// ============================================================================
//  Module      : pwm_channel
//  Description : One PWM channel: shadow/active duty, compare, gating, output flop.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_channel #(
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [DATA_W-1:0] cnt,
  input  wire logic              load,
  input  wire logic              wr_sel,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic              en,
  input  wire logic              mode,
  output logic      [DATA_W-1:0] shadow,
  output logic                   pwm
);
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] r_active;
  logic              r_pwm;
  logic              w_raw;

  assign w_raw = (cnt < r_active);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (wr_sel) r_shadow <= wr_data;
      // a write landing on the load cycle goes straight to the active copy
      if (load)   r_active <= wr_sel ? wr_data : r_shadow;
      r_pwm <= en & (mode ? w_raw : 1'b1);
    end
  end

  assign shadow = r_shadow;
  assign pwm    = r_pwm;
endmodule

`default_nettype wire

// File: rtl/pwm_bank.sv
// ============================================================================
//  Module      : pwm_bank
//  Description : N-channel PWM bank with prescaler, buffered duties and readback.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 7,
  parameter int PRESC_W = 8
) (
  input wire logic  clk,
  input wire logic  rst,
  pwm_bank_if.slave bus
);
  localparam logic [DATA_W-1:0] c_CNT_MAX = {{(DATA_W-1){1'b1}}, 1'b0};

  logic [NUM_CH-1:0]  r_en_out;
  logic [NUM_CH-1:0]  r_mode;
  logic [PRESC_W-1:0] r_prescale;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [DATA_W-1:0]  r_cnt;
  logic               r_first;
  logic               r_period_start;
  logic [DATA_W-1:0]  r_rd_data;
  logic               r_rd_valid;

  logic               w_tick;
  logic               w_wrap;
  logic               w_load;
  logic [NUM_CH-1:0]  w_duty_sel;
  logic [NUM_CH-1:0]  w_pwm;
  logic [DATA_W-1:0]  w_shadow [NUM_CH];
  logic [DATA_W-1:0]  w_rd_val;

  // >= rather than == so that lowering PRESCALE below the count ticks at once
  assign w_tick = (r_presc_cnt >= r_prescale);
  assign w_wrap = w_tick && (r_cnt == c_CNT_MAX);
  assign w_load = w_tick && (w_wrap || r_first);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_out       <= '0;
      r_mode         <= '0;
      r_prescale     <= '0;
      r_presc_cnt    <= '0;
      r_cnt          <= '0;
      r_first        <= 1'b1;
      r_period_start <= 1'b0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        case (bus.wr_addr)
          ADDR_W'(ADDR_EN_OUT):   r_en_out   <= bus.wr_data[NUM_CH-1:0];
          ADDR_W'(ADDR_PWM_MODE): r_mode     <= bus.wr_data[NUM_CH-1:0];
          ADDR_W'(ADDR_PRESCALE): r_prescale <= bus.wr_data[PRESC_W-1:0];
          default: ;
        endcase
      end
      r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_W'(1);
      if (w_tick) begin
        r_cnt   <= w_wrap ? '0 : r_cnt + DATA_W'(1);
        r_first <= 1'b0;
      end
      r_period_start <= w_wrap;
      r_rd_valid     <= bus.rd_en;
      r_rd_data      <= bus.rd_en ? w_rd_val : '0;
    end
  end

  always_comb begin
    w_rd_val = '0;
    case (bus.rd_addr)
      ADDR_W'(ADDR_EN_OUT):   w_rd_val = DATA_W'(r_en_out);
      ADDR_W'(ADDR_PWM_MODE): w_rd_val = DATA_W'(r_mode);
      ADDR_W'(ADDR_PRESCALE): w_rd_val = DATA_W'(r_prescale);
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_addr == ADDR_W'(ADDR_DUTY_BASE + i)) w_rd_val = w_shadow[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_duty_sel[g] = bus.wr_en && (bus.wr_addr == ADDR_W'(ADDR_DUTY_BASE + g));

    pwm_channel #(.DATA_W(DATA_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (r_cnt),
      .load    (w_load),
      .wr_sel  (w_duty_sel[g]),
      .wr_data (bus.wr_data),
      .en      (r_en_out[g]),
      .mode    (r_mode[g]),
      .shadow  (w_shadow[g]),
      .pwm     (w_pwm[g])
    );
  end

  assign bus.pwm_out      = w_pwm;
  assign bus.period_start = r_period_start;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
endmodule

`default_nettype wire
